// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// Load/store is favoured; a bounded streak of D grants keeps fetch moving.
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 1,
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    output logic        d_ready,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_write,
    output logic [1:0]  mem_access_size,
    input  logic [31:0] mem_data_out,
    output logic        busy
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(MEM_LATENCY - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_RESP   = 2'b10;

    function automatic logic d_aligned(input logic [1:0] size, input logic [1:0] lsb);
        logic ok;
        case (size)
            2'b00:   ok = 1'b1;
            2'b01:   ok = (lsb[0] == 1'b0);
            2'b10:   ok = (lsb == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0]    size_q, size_d;
    logic          we_q, we_d, owner_d_q, owner_d_d;
    logic          mem_write_q, mem_write_d;
    logic          if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
    logic          idle_s, d_grant_s, if_grant_s;

    // IF wins a contended cycle only once the D streak has saturated
    assign idle_s     = (state_q == ST_IDLE);
    assign d_grant_s  = idle_s && d_req && !(if_req && (streak_q == STREAK_MAX));
    assign if_grant_s = idle_s && if_req && !d_grant_s;

    // Next-state and capture logic for the transaction sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        we_d        = we_q;
        owner_d_d   = owner_d_q;
        rdata_d     = rdata_q;
        mem_write_d = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        d_err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (d_grant_s) begin
                    owner_d_d = 1'b1;
                    if (if_req) begin
                        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
                    end else begin
                        streak_d = '0;
                    end
                    // Rejected requests never touch the memory-side registers
                    if (!d_aligned(d_size, d_addr[1:0])) begin
                        state_d    = ST_RESP;
                        rdata_d    = 32'h0000_0000;
                        d_rvalid_d = 1'b1;
                        d_err_d    = 1'b1;
                    end else begin
                        state_d     = ST_ACCESS;
                        cnt_d       = '0;
                        addr_d      = d_addr;
                        wdata_d     = d_wdata;
                        size_d      = d_size;
                        we_d        = d_we;
                        mem_write_d = d_we;
                    end
                end else if (if_grant_s) begin
                    owner_d_d = 1'b0;
                    streak_d  = '0;
                    state_d   = ST_ACCESS;
                    cnt_d     = '0;
                    addr_d    = if_addr;
                    wdata_d   = 32'h0000_0000;
                    size_d    = 2'b10;
                    we_d      = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    if (we_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_RESP;
                        rdata_d     = mem_data_out;
                        if_rvalid_d = !owner_d_q;
                        d_rvalid_d  = owner_d_q;
                    end
                end else begin
                    cnt_d       = cnt_q + CW'(1);
                    mem_write_d = we_q;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            streak_q    <= '0;
            addr_q      <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            size_q      <= 2'b00;
            we_q        <= 1'b0;
            owner_d_q   <= 1'b0;
            rdata_q     <= 32'h0000_0000;
            mem_write_q <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            we_q        <= we_d;
            owner_d_q   <= owner_d_d;
            rdata_q     <= rdata_d;
            mem_write_q <= mem_write_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            d_err_q     <= d_err_d;
        end
    end

    assign if_ready        = if_grant_s;
    assign d_ready         = d_grant_s;
    assign if_rvalid       = if_rvalid_q;
    assign if_rdata        = rdata_q;
    assign d_rvalid        = d_rvalid_q;
    assign d_rdata         = rdata_q;
    assign d_err           = d_err_q;
    assign mem_address     = addr_q;
    assign mem_data_in     = wdata_q;
    assign mem_write       = mem_write_q;
    assign mem_access_size = size_q;
    assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: request-level reference model predicts grants, writes and responses.
module tb_mem_port_arbiter;

    localparam int L    = 1;
    localparam int MAXD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
    logic [1:0]  d_size = 2'b00;
    logic        if_ready, if_rvalid, d_ready, d_rvalid, d_err, mem_write, busy;
    logic [31:0] if_rdata, d_rdata, mem_address, mem_data_in, mem_data_out;
    logic [1:0]  mem_access_size;

    mem_port_arbiter #(.MEM_LATENCY(L), .MAX_D_STREAK(MAXD)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_ready(d_ready), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_write(mem_write), .mem_access_size(mem_access_size),
        .mem_data_out(mem_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic err; int due; } rsp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic [1:0] size; int first; int last; } wr_t;

    rsp_t iq[$];
    rsp_t dq[$];
    wr_t  wq[$];
    logic glog[$];
    logic [31:0] env_mem [64];
    logic [31:0] shadow [64];
    int   cyc = 0, checks = 0, errors = 0, wr_cycles = 0;
    int   next_free = 0, m_streak = 0;
    logic log_en = 1'b0;
    logic [31:0] last_if_rdata = 32'h0, last_d_rdata = 32'h0;
    logic last_d_err = 1'b0;

    // Memory places right-aligned store data into the addressed byte lanes
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [1:0] size, input logic [1:0] a);
        logic [31:0] r;
        r = old;
        if (size == 2'b00) r[a*8 +: 8] = data[7:0];
        else if (size == 2'b01) r[a[1]*16 +: 16] = data[15:0];
        else r = data;
        return r;
    endfunction

    function automatic logic legal(input logic [1:0] size, input logic [31:0] a);
        if (size == 2'b11) return 1'b0;
        if (size == 2'b10) return (a % 4) == 0;
        if (size == 2'b01) return (a % 2) == 0;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    assign mem_data_out = env_mem[mem_address[7:2]];

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        if (mem_write)
            env_mem[mem_address[7:2]] <= merge(env_mem[mem_address[7:2]], mem_data_in,
                                               mem_access_size, mem_address[1:0]);
    end

    // Monitor: predicts arbitration and checks writes/responses each cycle
    initial forever begin
        logic free, exp_d, exp_if;
        @(negedge clk);
        if (!rst_n) begin
            iq.delete(); dq.delete(); wq.delete();
            m_streak = 0; next_free = 0;
        end else begin
            free   = (cyc >= next_free);
            exp_d  = free && d_req && !(if_req && m_streak == MAXD);
            exp_if = free && if_req && !exp_d;
            chk("d_ready", d_ready, exp_d);
            chk("if_ready", if_ready, exp_if);
            chk("busy", busy, !free);
            if (log_en && (d_ready || if_ready)) glog.push_back(d_ready);
            if (mem_write) wr_cycles++;
            if (wq.size() > 0 && cyc >= wq[0].first && cyc <= wq[0].last) begin
                chk("mem_write", mem_write, 1);
                chk("wr_addr", mem_address, wq[0].addr);
                chk("wr_data", mem_data_in, wq[0].data);
                chk("wr_size", mem_access_size, wq[0].size);
                if (cyc == wq[0].last) begin
                    shadow[wq[0].addr[7:2]] = merge(shadow[wq[0].addr[7:2]], wq[0].data,
                                                    wq[0].size, wq[0].addr[1:0]);
                    void'(wq.pop_front());
                end
            end else begin
                chk("mem_write_idle", mem_write, 0);
            end
            if (iq.size() > 0 && iq[0].due == cyc) begin
                chk("if_rvalid", if_rvalid, 1);
                chk("if_rdata", if_rdata, iq[0].data);
                last_if_rdata = if_rdata;
                void'(iq.pop_front());
            end else begin
                chk("if_rvalid_idle", if_rvalid, 0);
            end
            if (dq.size() > 0 && dq[0].due == cyc) begin
                chk("d_rvalid", d_rvalid, 1);
                chk("d_rdata", d_rdata, dq[0].data);
                chk("d_err", d_err, dq[0].err);
                last_d_rdata = d_rdata;
                last_d_err   = d_err;
                void'(dq.pop_front());
            end else begin
                chk("d_rvalid_idle", d_rvalid, 0);
            end
            if (exp_d) begin
                m_streak = if_req ? ((m_streak < MAXD) ? m_streak + 1 : MAXD) : 0;
                if (!legal(d_size, d_addr)) begin
                    dq.push_back('{32'h0, 1'b1, cyc + 1});
                    next_free = cyc + 2;
                end else if (d_we) begin
                    wq.push_back('{d_addr, d_wdata, d_size, cyc + 1, cyc + L});
                    next_free = cyc + L + 1;
                end else begin
                    dq.push_back('{shadow[d_addr[7:2]], 1'b0, cyc + L + 1});
                    next_free = cyc + L + 2;
                end
            end else if (exp_if) begin
                m_streak = 0;
                iq.push_back('{shadow[if_addr[7:2]], 1'b0, cyc + L + 1});
                next_free = cyc + L + 2;
            end
        end
    end

    task automatic do_if(input logic [31:0] a);
        bit ok = 0;
        @(posedge clk); #1;
        if_addr = a; if_req = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (if_ready) begin ok = 1; break; end
        end
        if (!ok) chk("if_grant_timeout", 0, 1);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic do_d(input logic we, input logic [31:0] a, input logic [31:0] w,
                        input logic [1:0] sz);
        bit ok = 0;
        @(posedge clk); #1;
        d_we = we; d_addr = a; d_wdata = w; d_size = sz; d_req = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (d_ready) begin ok = 1; break; end
        end
        if (!ok) chk("d_grant_timeout", 0, 1);
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy && iq.size() == 0 && dq.size() == 0 && wq.size() == 0) begin
                ok = 1; break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        logic [31:0] pre;
        bit ok;
        for (int i = 0; i < 64; i++) begin
            env_mem[i] = $urandom;
            shadow[i]  = env_mem[i];
        end
        env_mem[0] = 32'h9876_5432;
        shadow[0]  = 32'h9876_5432;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_flags", {if_ready, d_ready, if_rvalid, d_rvalid, d_err, mem_write, busy}, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_mem_addr", mem_address, 0);
        chk("rst_mem_din", mem_data_in, 0);
        chk("rst_mem_size", mem_access_size, 0);
        @(posedge clk); #2 rst_n = 1'b1;

        do_if(32'h8002_0000);
        wait_idle();
        chk("fetch_data", last_if_rdata, 32'h9876_5432);
        chk("fetch_no_write", wr_cycles, 0);

        do_d(1'b1, 32'h8002_0004, 32'hDEAD_BEEF, 2'b10);
        wait_idle();
        chk("store_write_cycles", wr_cycles, L);
        do_d(1'b0, 32'h8002_0004, 32'h0, 2'b10);
        wait_idle();
        chk("load_after_store", last_d_rdata, 32'hDEAD_BEEF);
        chk("load_no_err", last_d_err, 0);

        // Both requesters held high: expect D,D,D,D,IF repeating
        @(posedge clk); #1;
        glog.delete(); log_en = 1'b1;
        if_addr = 32'h8002_0000; d_we = 1'b0; d_addr = 32'h8002_0008; d_size = 2'b10;
        if_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 200 && glog.size() < 10; k++) @(negedge clk);
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0; log_en = 1'b0;
        chk("grant_count", (glog.size() >= 10) ? 1 : 0, 1);
        for (int k = 0; k < 10 && k < glog.size(); k++)
            chk($sformatf("grant_order_%0d", k), glog[k], ((k % 5) == 4) ? 0 : 1);
        wait_idle();

        do_d(1'b0, 32'h8002_0001, 32'h0, 2'b01);
        wait_idle();
        chk("half_misaligned_err", last_d_err, 1);
        chk("half_misaligned_data", last_d_rdata, 0);
        do_d(1'b1, 32'h8002_0008, 32'h5555_AAAA, 2'b11);
        wait_idle();
        chk("size11_err", last_d_err, 1);
        chk("size11_data", last_d_rdata, 0);
        chk("err_no_write", wr_cycles, L);

        // Reset in the middle of a store's ACCESS cycle
        pre = shadow[4];
        @(posedge clk); #1;
        d_we = 1'b1; d_addr = 32'h8002_0010; d_wdata = 32'h1122_3344; d_size = 2'b10;
        d_req = 1'b1;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (d_ready) begin ok = 1; break; end
        end
        if (!ok) chk("abort_grant_timeout", 0, 1);
        @(posedge clk); #1;
        d_req = 1'b0;
        chk("abort_write_before", mem_write, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_mem_write", mem_write, 0);
        chk("abort_busy", busy, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        do_if(32'h8002_0010);
        wait_idle();
        chk("fetch_after_abort", last_if_rdata, pre);

        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    do_if(32'h8002_0000 | ($urandom_range(0, 63) << 2));
                end
            end
            begin
                for (int n = 0; n < 150; n++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    do_d($urandom_range(0, 1), 32'h8002_0000 | $urandom_range(0, 255),
                         $urandom, 2'($urandom_range(0, 3)));
                end
            end
        join
        wait_idle();
        chk("queues_drained", iq.size() + dq.size() + wq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
